uart_tx_mmio: RTL



---
 rtl/uart_tx_mmio.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter. A TXDATA store is queued in a FIFO; reads answer one cycle after the request.
// A store to a full FIFO with no pop in the same cycle is dropped and sets the sticky overflow flag. There is no bus stall.

module uart_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty,
  output logic         empty_nxt,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         push_ok, pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop_rdy && !empty;
  // A pop in the same cycle frees the slot, so a push to a full FIFO is still taken.
  assign push_ok = push_vld && (!full || pop_ok);
  assign drop    = push_vld && !push_ok;
  assign pop_dat = mem[rd_ptr[AW-1:0]];
  assign empty_nxt = ((wr_ptr + (AW+1)'(push_ok)) == (rd_ptr + (AW+1)'(pop_ok)));

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

module uart_tx_mmio #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 868
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        tx_o,
  output logic        irq_o
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [3:0] A_TXDATA = 4'h0;
  localparam logic [3:0] A_STATUS = 4'h4;
  localparam logic [3:0] A_BAUD   = 4'h8;
  localparam logic [31:0] DEF_DIV32 = DEFAULT_DIV;

  state_t      state;
  logic [15:0] baud_div;
  logic [15:0] cnt;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic        ier, ovf;

  logic        wr, rd, push, pop, ier_nxt;
  logic [7:0]  fifo_dat;
  logic        fifo_full, fifo_empty, fifo_empty_nxt, fifo_drop;
  logic [15:0] reload;
  logic [31:0] status, rd_mux;

  assign wr     = req_i && we_i;
  assign rd     = req_i && !we_i;
  assign push   = wr && (addr_i == A_TXDATA);
  assign reload = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
  assign pop    = !fifo_empty && ((state == IDLE) || ((state == STOP) && (cnt == 16'd0)));

  uart_tx_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .push_vld  (push),
    .push_dat  (wdata_i[7:0]),
    .pop_rdy   (pop),
    .pop_dat   (fifo_dat),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .empty_nxt (fifo_empty_nxt),
    .drop      (fifo_drop)
  );

  assign status = {27'd0, ier, ovf, (state != IDLE), fifo_empty, fifo_full};

  always_comb begin
    rd_mux = 32'd0;
    case (addr_i)
      A_STATUS: rd_mux = status;
      A_BAUD:   rd_mux = {16'd0, baud_div};
      default:  rd_mux = 32'd0;
    endcase
  end

  assign ier_nxt = (wr && (addr_i == A_STATUS)) ? wdata_i[4] : ier;

  // Register block: bus writes, read response, sticky flags and the interrupt.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      baud_div <= DEF_DIV32[15:0];
      ier      <= 1'b0;
      ovf      <= 1'b0;
      rdata_o  <= 32'd0;
      rvalid_o <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      rvalid_o <= rd;
      rdata_o  <= rd ? rd_mux : 32'd0;
      ier      <= ier_nxt;
      irq_o    <= ier_nxt && fifo_empty_nxt;
      if (wr && (addr_i == A_BAUD)) baud_div <= wdata_i[15:0];
      if (fifo_drop) ovf <= 1'b1;
      else if (wr && (addr_i == A_STATUS) && wdata_i[3]) ovf <= 1'b0;
    end
  end

  // Each START/DATA/STOP bit is held for reload+1 cycles; the divider is sampled at every reload.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      tx_o    <= 1'b1;
      cnt     <= 16'd0;
      shift   <= 8'd0;
      bit_cnt <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          tx_o <= 1'b1;
          if (!fifo_empty) begin
            shift   <= fifo_dat;
            bit_cnt <= 3'd0;
            cnt     <= reload;
            tx_o    <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else begin
            tx_o  <= shift[0];
            shift <= shift >> 1;
            cnt   <= reload;
            state <= DATA;
          end
        end
        DATA: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else begin
            cnt <= reload;
            if (bit_cnt == 3'd7) begin
              tx_o  <= 1'b1;
              state <= STOP;
            end else begin
              tx_o    <= shift[0];
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        STOP: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else if (!fifo_empty) begin
            shift   <= fifo_dat;
            bit_cnt <= 3'd0;
            cnt     <= reload;
            tx_o    <= 1'b0;
            state   <= START;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          tx_o  <= 1'b1;
        end
      endcase
    end
  end
endmodule
